// File: rtl/sky130_sram_1rw1r_arbiter.sv
// Two-requester arbiter for a 1RW+1R OpenRAM macro: read data returns 2 edges after handshake, responses are never stalled,
// losing/hazarding requests see ready=0 and retry. Define SRAM_ARB_WR_FWD_EN to forward same-cycle write data to a hazarding read.
module sky130_sram_1rw1r_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

  owner_e                prio;
  owner_e                p0_own, p1_own, rd_own;
  logic                  a_rd, a_wr, b_rd, b_wr;
  logic                  p0_gnt, p0_we, p1_gnt, fwd, hazard;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, p0_addr, p1_addr;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] p0_din, din0_q, fwd_dat;
  logic                  t0_vld, t1_vld, fwd_vld;
  owner_e                t0_own, t1_own, fwd_own;
  logic                  a_stall, b_stall, flip;
  logic                  a_hit0, a_hit1, a_hitf, b_hit0, b_hit1, b_hitf;

  assign a_rd = a_req_valid && !a_req_we;
  assign a_wr = a_req_valid && a_req_we;
  assign b_rd = b_req_valid && !b_req_we;
  assign b_wr = b_req_valid && b_req_we;

  assign rd_own  = a_rd ? OWN_A : OWN_B;
  assign rd_addr = a_rd ? a_req_addr : b_req_addr;
  assign wr_addr = a_wr ? a_req_addr : b_req_addr;

  always_comb begin
    p0_gnt = 1'b0;
    p0_own = OWN_A;
    p1_gnt = 1'b0;
    p1_own = OWN_A;
    fwd    = 1'b0;
    hazard = 1'b0;
    if (!rst) begin
      if (a_rd && b_rd) begin
        p1_gnt = 1'b1;
        p1_own = prio;
        p0_gnt = 1'b1;
        p0_own = (prio == OWN_A) ? OWN_B : OWN_A;
      end else if (a_wr && b_wr) begin
        p0_gnt = 1'b1;
        p0_own = prio;
      end else begin
        // At most one writer and one reader here, necessarily different requesters.
        if (a_wr || b_wr) begin
          p0_gnt = 1'b1;
          p0_own = a_wr ? OWN_A : OWN_B;
        end
        hazard = (a_wr || b_wr) && (rd_addr == wr_addr);
        if (a_rd || b_rd) begin
          if (!hazard) begin
            p1_gnt = 1'b1;
            p1_own = rd_own;
          end
`ifdef SRAM_ARB_WR_FWD_EN
          else begin
            fwd = 1'b1;
          end
`endif
        end
      end
    end
  end

  assign p0_addr = (p0_own == OWN_A) ? a_req_addr : b_req_addr;
  assign p0_din  = (p0_own == OWN_A) ? a_req_wdata : b_req_wdata;
  assign p0_we   = p0_gnt && ((p0_own == OWN_A) ? a_req_we : b_req_we);
  assign p1_addr = (p1_own == OWN_A) ? a_req_addr : b_req_addr;

  assign a_req_ready = (p0_gnt && p0_own == OWN_A) || (p1_gnt && p1_own == OWN_A) || (fwd && rd_own == OWN_A);
  assign b_req_ready = (p0_gnt && p0_own == OWN_B) || (p1_gnt && p1_own == OWN_B) || (fwd && rd_own == OWN_B);

  assign sram_csb0  = !p0_gnt;
  assign sram_web0  = !p0_we;
  assign sram_addr0 = p0_gnt ? p0_addr : addr0_q;
  assign sram_din0  = p0_we ? p0_din : din0_q;
  assign sram_csb1  = !p1_gnt;
  assign sram_addr1 = p1_gnt ? p1_addr : addr1_q;

  assign a_stall = a_req_valid && !a_req_ready;
  assign b_stall = b_req_valid && !b_req_ready;
  assign flip    = (a_stall && b_req_ready) || (b_stall && a_req_ready);

  assign a_hit0 = t0_vld && t0_own == OWN_A;
  assign a_hit1 = t1_vld && t1_own == OWN_A;
  assign a_hitf = fwd_vld && fwd_own == OWN_A;
  assign b_hit0 = t0_vld && t0_own == OWN_B;
  assign b_hit1 = t1_vld && t1_own == OWN_B;
  assign b_hitf = fwd_vld && fwd_own == OWN_B;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= OWN_A;
      t0_vld      <= 1'b0;
      t0_own      <= OWN_A;
      t1_vld      <= 1'b0;
      t1_own      <= OWN_A;
      fwd_vld     <= 1'b0;
      fwd_own     <= OWN_A;
      fwd_dat     <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      din0_q      <= '0;
      a_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_valid <= 1'b0;
      b_rsp_rdata <= '0;
    end else begin
      if (flip) prio <= (prio == OWN_A) ? OWN_B : OWN_A;
      t0_vld  <= p0_gnt && !p0_we;
      t0_own  <= p0_own;
      t1_vld  <= p1_gnt;
      t1_own  <= p1_own;
      fwd_vld <= fwd;
      fwd_own <= rd_own;
      fwd_dat <= p0_din;
      addr0_q <= sram_addr0;
      addr1_q <= sram_addr1;
      din0_q  <= sram_din0;
      // Tags say which macro port holds each requester's data this cycle.
      a_rsp_valid <= a_hit0 || a_hit1 || a_hitf;
      if (a_hit1) a_rsp_rdata <= sram_dout1;
      else if (a_hit0) a_rsp_rdata <= sram_dout0;
      else if (a_hitf) a_rsp_rdata <= fwd_dat;
      b_rsp_valid <= b_hit0 || b_hit1 || b_hitf;
      if (b_hit1) b_rsp_rdata <= sram_dout1;
      else if (b_hit0) b_rsp_rdata <= sram_dout0;
      else if (b_hitf) b_rsp_rdata <= fwd_dat;
    end
  end
endmodule

// File: tb/tb_sky130_sram_1rw1r_arbiter.sv
// Bench for sky130_sram_1rw1r_arbiter: macro model, transaction-level reference model, directed and random traffic.
module tb_sky130_sram_1rw1r_arbiter;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sky130_sram_1rw1r_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'(32'h9E3779B9 * (i + 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Macro model: registered read data, write on port 0.
  logic [DW-1:0] mem [DEPTH];
  logic mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else begin
      if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
      if (!sram_csb0 && sram_web0) sram_dout0 <= mem[sram_addr0];
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end
  end

  // Reference model: who wins, what memory holds, what each requester sees two edges later.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          m_prio, armed;
  logic          ag, bg, fwd_hit;
  logic          s1_a_v, s1_b_v, cur_a_v, cur_b_v;
  logic [DW-1:0] s1_a_d, s1_b_d, cur_a_d, cur_b_d, exp_a_d, exp_b_d;
  int            nr, nw;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    armed = 1'b0; m_prio = 1'b0;
    s1_a_v = 1'b0; s1_b_v = 1'b0; cur_a_v = 1'b0; cur_b_v = 1'b0;
    s1_a_d = '0; s1_b_d = '0; cur_a_d = '0; cur_b_d = '0; exp_a_d = '0; exp_b_d = '0;
    forever begin
      @(negedge clk);
      ag = 1'b0; bg = 1'b0; fwd_hit = 1'b0;
      if (!rst) begin
        if (a_req_valid && b_req_valid) begin
          if (a_req_we && b_req_we) begin
            ag = !m_prio;
            bg = m_prio;
          end else if ((a_req_we != b_req_we) && (a_req_addr == b_req_addr)) begin
`ifdef SRAM_ARB_WR_FWD_EN
            ag = 1'b1; bg = 1'b1; fwd_hit = 1'b1;
`else
            ag = a_req_we; bg = b_req_we;
`endif
          end else begin
            ag = 1'b1; bg = 1'b1;
          end
        end else begin
          ag = a_req_valid; bg = b_req_valid;
        end
      end
      nr = int'(ag && !a_req_we) + int'(bg && !b_req_we);
      nw = int'(ag && a_req_we) + int'(bg && b_req_we);

      if (armed) begin
        check("a_rsp_valid", 32'(a_rsp_valid), 32'(cur_a_v));
        check("a_rsp_rdata", a_rsp_rdata, exp_a_d);
        check("b_rsp_valid", 32'(b_rsp_valid), 32'(cur_b_v));
        check("b_rsp_rdata", b_rsp_rdata, exp_b_d);
      end
      check("a_req_ready", 32'(a_req_ready), 32'(ag));
      check("b_req_ready", 32'(b_req_ready), 32'(bg));
      check("csb0", 32'(sram_csb0), 32'(!(nw > 0 || nr == 2)));
      check("web0", 32'(sram_web0), 32'(!(nw > 0)));
      check("csb1", 32'(sram_csb1), 32'(!(nr > 0 && !fwd_hit)));
      check("no_same_addr_wr_rd", 32'(!sram_csb0 && !sram_web0 && !sram_csb1 && sram_addr0 == sram_addr1), 32'd0);
      if (nr > 0 && !fwd_hit)
        check("addr1", 32'(sram_addr1), 32'((nr == 2) ? (m_prio ? b_req_addr : a_req_addr)
                                                       : ((ag && !a_req_we) ? a_req_addr : b_req_addr)));
      if (nw > 0) begin
        check("addr0_wr", 32'(sram_addr0), 32'((ag && a_req_we) ? a_req_addr : b_req_addr));
        check("din0", sram_din0, (ag && a_req_we) ? a_req_wdata : b_req_wdata);
      end else if (nr == 2) begin
        check("addr0_rd", 32'(sram_addr0), 32'(m_prio ? a_req_addr : b_req_addr));
      end

      if (rst) begin
        m_prio = 1'b0;
        s1_a_v = 1'b0; s1_b_v = 1'b0; cur_a_v = 1'b0; cur_b_v = 1'b0;
        exp_a_d = '0; exp_b_d = '0;
        armed = 1'b1;
      end else begin
        cur_a_v = s1_a_v; cur_a_d = s1_a_d;
        cur_b_v = s1_b_v; cur_b_d = s1_b_d;
        if (cur_a_v) exp_a_d = cur_a_d;
        if (cur_b_v) exp_b_d = cur_b_d;
        // Writes land first so a forwarded read observes the new word.
        if (ag && a_req_we) ref_mem[a_req_addr] = a_req_wdata;
        if (bg && b_req_we) ref_mem[b_req_addr] = b_req_wdata;
        s1_a_v = ag && !a_req_we; s1_a_d = ref_mem[a_req_addr];
        s1_b_v = bg && !b_req_we; s1_b_d = ref_mem[b_req_addr];
        if ((a_req_valid && !ag && bg) || (b_req_valid && !bg && ag)) m_prio = !m_prio;
      end
    end
  end

  // Driver with per-cycle snapshot for literal checks.
  logic          s_a_rdy, s_b_rdy, s_csb0, s_csb1, s_a_rv, s_b_rv;
  logic [AW-1:0] s_addr1;
  logic [DW-1:0] s_a_rd, s_b_rd;

  task automatic drive(input logic r,
                       input logic av, input logic awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic bv, input logic bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    rst = r;
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    @(negedge clk);
    s_a_rdy = a_req_ready; s_b_rdy = b_req_ready;
    s_csb0 = sram_csb0; s_csb1 = sram_csb1; s_addr1 = sram_addr1;
    s_a_rv = a_rsp_valid; s_a_rd = a_rsp_rdata;
    s_b_rv = b_rsp_valid; s_b_rd = b_rsp_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
  endfunction

  logic          ra_v, ra_we, rb_v, rb_we;
  logic [AW-1:0] ra_ad, rb_ad;
  logic [DW-1:0] ra_wd, rb_wd;
  int            ka, kb;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit %0t", $time);
    $fatal(1);
  end

  initial begin
    // 1: reset, write then read back
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    mem_init = 1'b0;
    check("t1_rst_csb0", 32'(s_csb0), 32'd1);
    check("t1_rst_csb1", 32'(s_csb1), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 7'h05, '0, 1'b1, 1'b0, 7'h06, '0);
    check("t1_rst_a_ready", 32'(s_a_rdy), 32'd0);
    check("t1_rst_b_ready", 32'(s_b_rdy), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    check("t1_wr_ready", 32'(s_a_rdy), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 7'h05, '0, 1'b0, 1'b0, '0, '0);
    check("t1_rd_ready", 32'(s_a_rdy), 32'd1);
    idle();
    check("t1_rsp_early", 32'(s_a_rv), 32'd0);
    idle();
    check("t1_rsp_valid", 32'(s_a_rv), 32'd1);
    check("t1_rsp_data", s_a_rd, 32'hDEADBEEF);
    idle();
    check("t1_rsp_pulse", 32'(s_a_rv), 32'd0);
    check("t1_rsp_hold", s_a_rd, 32'hDEADBEEF);

    // 2: dual read, A has priority on port 1
    drive(1'b0, 1'b1, 1'b1, 7'h10, 32'h1, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h11, 32'h2);
    drive(1'b0, 1'b1, 1'b0, 7'h10, '0, 1'b1, 1'b0, 7'h11, '0);
    check("t2_a_ready", 32'(s_a_rdy), 32'd1);
    check("t2_b_ready", 32'(s_b_rdy), 32'd1);
    check("t2_addr1", 32'(s_addr1), 32'h10);
    idle();
    idle();
    check("t2_a_rsp", s_a_rd, 32'h1);
    check("t2_b_rsp", s_b_rd, 32'h2);
    check("t2_both_valid", 32'({s_a_rv, s_b_rv}), 32'd3);

    // 3: write/read hazard on the same address
    drive(1'b0, 1'b1, 1'b1, 7'h20, 32'h0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 7'h20, 32'h55, 1'b1, 1'b0, 7'h20, '0);
    check("t3_a_ready", 32'(s_a_rdy), 32'd1);
`ifdef SRAM_ARB_WR_FWD_EN
    check("t3_b_ready_fwd", 32'(s_b_rdy), 32'd1);
    check("t3_csb1_fwd", 32'(s_csb1), 32'd1);
    idle();
`else
    check("t3_b_stall", 32'(s_b_rdy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h20, '0);
    check("t3_b_retry", 32'(s_b_rdy), 32'd1);
    idle();
`endif
    idle();
    check("t3_b_rsp_valid", 32'(s_b_rv), 32'd1);
    check("t3_b_rsp_data", s_b_rd, 32'h55);

    // 6: top address
    drive(1'b0, 1'b1, 1'b1, 7'h7F, 32'hFFFFFFFF, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 7'h7F, '0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();
    check("t6_rsp_valid", 32'(s_a_rv), 32'd1);
    check("t6_rsp_data", s_a_rd, 32'hFFFFFFFF);

    // 5: reset right after a read handshake drops the response
    drive(1'b0, 1'b1, 1'b0, 7'h05, '0, 1'b0, 1'b0, '0, '0);
    check("t5_rd_ready", 32'(s_a_rdy), 32'd1);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    check("t5_rst_csb0", 32'(s_csb0), 32'd1);
    idle();
    check("t5_no_rsp", 32'(s_a_rv), 32'd0);
    check("t5_rdata_cleared", s_a_rd, 32'd0);
    idle();
    check("t5_still_no_rsp", 32'(s_a_rv), 32'd0);

    // 4: contending writes alternate starting with A after reset
    ka = 0; kb = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 7'(8'h30 + ka), 32'hA0000000 + 32'(ka),
                  1'b1, 1'b1, 7'(8'h40 + kb), 32'hB0000000 + 32'(kb));
      check("t4_a_grant", 32'(s_a_rdy), 32'((k % 2) == 0));
      check("t4_b_grant", 32'(s_b_rdy), 32'((k % 2) == 1));
      if (s_a_rdy) ka++;
      if (s_b_rdy) kb++;
    end

    // Random traffic on a small address window to provoke hazards and contention
    ra_v = 1'b0; rb_v = 1'b0; ra_we = 1'b0; rb_we = 1'b0;
    ra_ad = '0; rb_ad = '0; ra_wd = '0; rb_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (ra_v && !s_a_rdy) begin
        if ($urandom_range(0, 9) == 0) ra_v = 1'b0;
      end else begin
        ra_v = ($urandom_range(0, 3) != 0);
        ra_we = 1'($urandom_range(0, 1));
        ra_ad = pick_addr();
        ra_wd = $urandom;
      end
      if (rb_v && !s_b_rdy) begin
        if ($urandom_range(0, 9) == 0) rb_v = 1'b0;
      end else begin
        rb_v = ($urandom_range(0, 3) != 0);
        rb_we = 1'($urandom_range(0, 1));
        rb_ad = pick_addr();
        rb_wd = $urandom;
      end
      drive(($urandom_range(0, 149) == 0), ra_v, ra_we, ra_ad, ra_wd, rb_v, rb_we, rb_ad, rb_wd);
    end
    idle();
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
